// File: rtl/serial_adder.sv
// Digit-serial adder: streams two WIDTH-bit operands through a DIGIT-bit ripple slice, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via ~b and forced carry-in).
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             load, step, last;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    logic [DIGIT:0]         digit_sum;
    logic [DIGIT-1:0]       digit_bits;
    logic                   digit_cout;
    logic                   msb_cin;
    logic [WIDTH+DIGIT-1:0] sum_cat;
    logic [WIDTH-1:0]       sum_shift;

    // Operand conditioning at start: subtraction is a + ~b + 1.
    always_comb begin
        b_in = b;
        c_in = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_in = ~b;
            c_in = 1'b1;
        end
`endif
    end

    // One DIGIT-bit ripple slice; the carry into the MSB is recovered from the
    // top bit of the slice as a ^ b ^ sum, so it is valid for any DIGIT.
    always_comb begin
        digit_sum  = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        digit_bits = digit_sum[DIGIT-1:0];
        digit_cout = digit_sum[DIGIT];
        msb_cin    = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ digit_bits[DIGIT-1];
        sum_cat    = {digit_bits, sum_sh};
        sum_shift  = sum_cat[WIDTH+DIGIT-1:DIGIT];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST_DIGIT) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Working registers; start while RUN never reaches load, so it has no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b_in;
            carry <= c_in;
            cnt   <= '0;
        end else if (step) begin
            a_sh   <= a_sh >> DIGIT;
            b_sh   <= b_sh >> DIGIT;
            sum_sh <= sum_shift;
            carry  <= digit_cout;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Visible results only move on the final digit, so partial sums never leak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            if (last) begin
                sum  <= sum_shift;
                cout <= digit_cout;
                ovf  <= msb_cin ^ digit_cout;
            end
            done <= last;
            busy <= (state_next == RUN);
        end
    end

endmodule
